// File: rtl/cpu_pipe_pkg.sv
// Shared pipeline types for the decode-side operand-fetch stage.
// Register-bank geometry is fixed here for the whole pipeline.
package cpu_pipe_pkg;

  localparam int unsigned NUM_REGS  = 32;
  localparam int unsigned REG_WIDTH = 32;
  localparam int unsigned REG_AW    = $clog2(NUM_REGS);

  typedef logic [REG_WIDTH-1:0] reg_data_t;
  typedef logic [REG_AW-1:0]    reg_idx_t;

  typedef struct packed {
    logic      valid;
    reg_data_t operand_a;
    reg_data_t operand_b;
    reg_idx_t  rd;
    logic      writes_rd;
    logic      is_load;
  } id_ex_t;

  typedef enum logic [1:0] {
    FWD_BANK = 2'd0,
    FWD_WB   = 2'd1,
    FWD_MEM  = 2'd2,
    FWD_EX   = 2'd3
  } fwd_sel_t;

endpackage

// File: rtl/cpu_operand_fetch_if.sv
// Bundle of decode, bank, bypass and ID/EX signals seen by the operand-fetch stage.
// slave is the stage itself; master is whatever drives it.
interface cpu_operand_fetch_if
  import cpu_pipe_pkg::*;
#(
  parameter int unsigned CNT_WIDTH = 32
);
  logic                 in_valid;
  logic                 in_ready;
  reg_idx_t             in_rs_a;
  reg_idx_t             in_rs_b;
  reg_idx_t             in_rd;
  logic                 in_use_a;
  logic                 in_use_b;
  logic                 in_writes_rd;
  logic                 in_is_load;

  reg_idx_t             bank_read_reg_a;
  reg_idx_t             bank_read_reg_b;
  reg_data_t            bank_read_data_a;
  reg_data_t            bank_read_data_b;

  logic                 ex_valid;
  logic                 ex_writes_rd;
  logic                 ex_is_load;
  reg_idx_t             ex_rd;
  reg_data_t            ex_result;

  logic                 mem_valid;
  logic                 mem_writes_rd;
  reg_idx_t             mem_rd;
  reg_data_t            mem_result;

  logic                 wb_write_enable;
  reg_idx_t             wb_write_reg;
  reg_data_t            wb_write_data;

  logic                 ex_stall;
  logic                 flush;

  logic                 out_valid;
  reg_data_t            out_operand_a;
  reg_data_t            out_operand_b;
  reg_idx_t             out_rd;
  logic                 out_writes_rd;
  logic                 out_is_load;
  logic [CNT_WIDTH-1:0] load_use_stalls;

  modport slave (
    input  in_valid, in_rs_a, in_rs_b, in_rd, in_use_a, in_use_b, in_writes_rd, in_is_load,
    input  bank_read_data_a, bank_read_data_b,
    input  ex_valid, ex_writes_rd, ex_is_load, ex_rd, ex_result,
    input  mem_valid, mem_writes_rd, mem_rd, mem_result,
    input  wb_write_enable, wb_write_reg, wb_write_data,
    input  ex_stall, flush,
    output in_ready, bank_read_reg_a, bank_read_reg_b,
    output out_valid, out_operand_a, out_operand_b, out_rd, out_writes_rd, out_is_load,
    output load_use_stalls
  );

  modport master (
    output in_valid, in_rs_a, in_rs_b, in_rd, in_use_a, in_use_b, in_writes_rd, in_is_load,
    output bank_read_data_a, bank_read_data_b,
    output ex_valid, ex_writes_rd, ex_is_load, ex_rd, ex_result,
    output mem_valid, mem_writes_rd, mem_rd, mem_result,
    output wb_write_enable, wb_write_reg, wb_write_data,
    output ex_stall, flush,
    input  in_ready, bank_read_reg_a, bank_read_reg_b,
    input  out_valid, out_operand_a, out_operand_b, out_rd, out_writes_rd, out_is_load,
    input  load_use_stalls
  );

endinterface

// File: rtl/cpu_fwd_mux.sv
// Per-operand bypass select: EX over MEM over WB over the bank read data.
// Loads in EX are excluded; their data is not ready until MEM.
module cpu_fwd_mux
  import cpu_pipe_pkg::*;
#(
  parameter bit ZERO_REG = 1'b1
) (
  input  reg_idx_t  rs_i,
  input  reg_data_t bank_data_i,
  input  logic      ex_valid_i,
  input  logic      ex_writes_rd_i,
  input  logic      ex_is_load_i,
  input  reg_idx_t  ex_rd_i,
  input  reg_data_t ex_result_i,
  input  logic      mem_valid_i,
  input  logic      mem_writes_rd_i,
  input  reg_idx_t  mem_rd_i,
  input  reg_data_t mem_result_i,
  input  logic      wb_write_enable_i,
  input  reg_idx_t  wb_write_reg_i,
  input  reg_data_t wb_write_data_i,
  output fwd_sel_t  sel_o,
  output reg_data_t data_o
);

  always_comb begin
    sel_o  = FWD_BANK;
    data_o = bank_data_i;
    if (ZERO_REG && (rs_i == '0)) begin
      data_o = '0;
    end else if (ex_valid_i && ex_writes_rd_i && !ex_is_load_i && (ex_rd_i == rs_i)) begin
      sel_o  = FWD_EX;
      data_o = ex_result_i;
    end else if (mem_valid_i && mem_writes_rd_i && (mem_rd_i == rs_i)) begin
      sel_o  = FWD_MEM;
      data_o = mem_result_i;
    end else if (wb_write_enable_i && (wb_write_reg_i == rs_i)) begin
      // Same-cycle bank write: the bank still returns the old value.
      sel_o  = FWD_WB;
      data_o = wb_write_data_i;
    end
  end

endmodule

// File: rtl/cpu_operand_fetch.sv
// Operand-fetch stage: bank addressing, bypass resolution, load-use bubble insertion
// and the ID/EX pipeline register.
module cpu_operand_fetch
  import cpu_pipe_pkg::*;
#(
  parameter bit          ZERO_REG  = 1'b1,
  parameter int unsigned CNT_WIDTH = 32
) (
  input logic               clk,
  input logic               rst_n,
  cpu_operand_fetch_if.slave bus_io
);

  localparam logic [CNT_WIDTH-1:0] CntMax = '1;

  fwd_sel_t             sel_a, sel_b;
  reg_data_t            fwd_a, fwd_b;
  logic                 load_use_a, load_use_b, load_use;
  id_ex_t               id_ex_q, id_ex_d;
  logic [CNT_WIDTH-1:0] stalls_q, stalls_d;

  assign bus_io.bank_read_reg_a = bus_io.in_rs_a;
  assign bus_io.bank_read_reg_b = bus_io.in_rs_b;

  cpu_fwd_mux #(.ZERO_REG(ZERO_REG)) u_fwd_a (
    .rs_i              (bus_io.in_rs_a),
    .bank_data_i       (bus_io.bank_read_data_a),
    .ex_valid_i        (bus_io.ex_valid),
    .ex_writes_rd_i    (bus_io.ex_writes_rd),
    .ex_is_load_i      (bus_io.ex_is_load),
    .ex_rd_i           (bus_io.ex_rd),
    .ex_result_i       (bus_io.ex_result),
    .mem_valid_i       (bus_io.mem_valid),
    .mem_writes_rd_i   (bus_io.mem_writes_rd),
    .mem_rd_i          (bus_io.mem_rd),
    .mem_result_i      (bus_io.mem_result),
    .wb_write_enable_i (bus_io.wb_write_enable),
    .wb_write_reg_i    (bus_io.wb_write_reg),
    .wb_write_data_i   (bus_io.wb_write_data),
    .sel_o             (sel_a),
    .data_o            (fwd_a)
  );

  cpu_fwd_mux #(.ZERO_REG(ZERO_REG)) u_fwd_b (
    .rs_i              (bus_io.in_rs_b),
    .bank_data_i       (bus_io.bank_read_data_b),
    .ex_valid_i        (bus_io.ex_valid),
    .ex_writes_rd_i    (bus_io.ex_writes_rd),
    .ex_is_load_i      (bus_io.ex_is_load),
    .ex_rd_i           (bus_io.ex_rd),
    .ex_result_i       (bus_io.ex_result),
    .mem_valid_i       (bus_io.mem_valid),
    .mem_writes_rd_i   (bus_io.mem_writes_rd),
    .mem_rd_i          (bus_io.mem_rd),
    .mem_result_i      (bus_io.mem_result),
    .wb_write_enable_i (bus_io.wb_write_enable),
    .wb_write_reg_i    (bus_io.wb_write_reg),
    .wb_write_data_i   (bus_io.wb_write_data),
    .sel_o             (sel_b),
    .data_o            (fwd_b)
  );

  always_comb begin
    load_use_a = bus_io.in_valid && bus_io.in_use_a && bus_io.ex_valid && bus_io.ex_is_load &&
                 bus_io.ex_writes_rd && (bus_io.ex_rd == bus_io.in_rs_a) &&
                 !(ZERO_REG && (bus_io.in_rs_a == '0));
    load_use_b = bus_io.in_valid && bus_io.in_use_b && bus_io.ex_valid && bus_io.ex_is_load &&
                 bus_io.ex_writes_rd && (bus_io.ex_rd == bus_io.in_rs_b) &&
                 !(ZERO_REG && (bus_io.in_rs_b == '0));
    load_use   = load_use_a || load_use_b;
  end

  assign bus_io.in_ready = !bus_io.ex_stall && !load_use && !bus_io.flush;

  always_comb begin
    id_ex_d  = id_ex_q;
    stalls_d = stalls_q;
    if (bus_io.flush) begin
      id_ex_d.valid = 1'b0;
    end else if (bus_io.ex_stall) begin
      id_ex_d = id_ex_q;
    end else if (load_use) begin
      id_ex_d.valid = 1'b0;
      if (stalls_q != CntMax) begin
        stalls_d = stalls_q + 1'b1;
      end
    end else begin
      id_ex_d.valid     = bus_io.in_valid;
      id_ex_d.operand_a = fwd_a;
      id_ex_d.operand_b = fwd_b;
      id_ex_d.rd        = bus_io.in_rd;
      id_ex_d.writes_rd = bus_io.in_writes_rd;
      id_ex_d.is_load   = bus_io.in_is_load;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      id_ex_q  <= '0;
      stalls_q <= '0;
    end else begin
      id_ex_q  <= id_ex_d;
      stalls_q <= stalls_d;
    end
  end

  // A load in EX must never be picked as a bypass source for a hazarding operand.
  a_no_ex_load_fwd : assert property (@(posedge clk) disable iff (!rst_n)
    !((sel_a == FWD_EX) && load_use_a) && !((sel_b == FWD_EX) && load_use_b));

  assign bus_io.out_valid       = id_ex_q.valid;
  assign bus_io.out_operand_a   = id_ex_q.operand_a;
  assign bus_io.out_operand_b   = id_ex_q.operand_b;
  assign bus_io.out_rd          = id_ex_q.rd;
  assign bus_io.out_writes_rd   = id_ex_q.writes_rd;
  assign bus_io.out_is_load     = id_ex_q.is_load;
  assign bus_io.load_use_stalls = stalls_q;

endmodule

// File: tb/tb_cpu_operand_fetch.sv
// Directed and randomized bench for cpu_operand_fetch against a register-file model.
module tb_cpu_operand_fetch;
  import cpu_pipe_pkg::*;

  localparam int unsigned TbCnt = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cpu_operand_fetch_if #(.CNT_WIDTH(TbCnt)) bus ();

  cpu_operand_fetch #(.ZERO_REG(1'b1), .CNT_WIDTH(TbCnt)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus_io (bus)
  );

  int checks = 0;
  int errors = 0;

  reg_data_t bank [NUM_REGS];
  logic      m_valid, m_wr, m_ld;
  reg_data_t m_a, m_b;
  reg_idx_t  m_rd;
  int        m_cnt;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Value an instruction should see for register rs, from the stage-ordering rules.
  function automatic reg_data_t ref_operand(input reg_idx_t rs);
    if (rs == 0) return '0;
    if (bus.ex_valid && bus.ex_writes_rd && !bus.ex_is_load && bus.ex_rd == rs)
      return bus.ex_result;
    if (bus.mem_valid && bus.mem_writes_rd && bus.mem_rd == rs) return bus.mem_result;
    if (bus.wb_write_enable && bus.wb_write_reg == rs) return bus.wb_write_data;
    return bank[rs];
  endfunction

  function automatic bit waits_on_load(input reg_idx_t rs, input logic used);
    return bus.in_valid && used && rs != 0 && bus.ex_valid && bus.ex_is_load &&
           bus.ex_writes_rd && bus.ex_rd == rs;
  endfunction

  task automatic set_idle();
    bus.in_valid = 0; bus.in_rs_a = 0; bus.in_rs_b = 0; bus.in_rd = 0;
    bus.in_use_a = 0; bus.in_use_b = 0; bus.in_writes_rd = 0; bus.in_is_load = 0;
    bus.ex_valid = 0; bus.ex_writes_rd = 0; bus.ex_is_load = 0; bus.ex_rd = 0; bus.ex_result = 0;
    bus.mem_valid = 0; bus.mem_writes_rd = 0; bus.mem_rd = 0; bus.mem_result = 0;
    bus.wb_write_enable = 0; bus.wb_write_reg = 0; bus.wb_write_data = 0;
    bus.ex_stall = 0; bus.flush = 0;
  endtask

  // One clock: check combinational outputs, predict the edge, check registered outputs.
  task automatic cycle();
    bit        lu, accept;
    reg_data_t opa, opb, wdata;
    reg_idx_t  wreg;
    bit        we;
    bus.bank_read_data_a = bank[bus.in_rs_a];
    bus.bank_read_data_b = bank[bus.in_rs_b];
    #1;
    lu = waits_on_load(bus.in_rs_a, bus.in_use_a) || waits_on_load(bus.in_rs_b, bus.in_use_b);
    chk("in_ready", bus.in_ready, !bus.ex_stall && !lu && !bus.flush);
    chk("bank_read_reg_a", bus.bank_read_reg_a, bus.in_rs_a);
    chk("bank_read_reg_b", bus.bank_read_reg_b, bus.in_rs_b);
    opa = ref_operand(bus.in_rs_a);
    opb = ref_operand(bus.in_rs_b);
    accept = !bus.flush && !bus.ex_stall && !lu;
    we = bus.wb_write_enable; wreg = bus.wb_write_reg; wdata = bus.wb_write_data;
    @(posedge clk);
    #1;
    if (we) bank[wreg] = wdata;
    if (rst_n == 1'b0) begin
      m_valid = 0; m_a = 0; m_b = 0; m_rd = 0; m_wr = 0; m_ld = 0; m_cnt = 0;
    end else if (bus.flush || lu) begin
      m_valid = 0;
      if (!bus.flush && !bus.ex_stall && m_cnt < (1 << TbCnt) - 1) m_cnt++;
      if (!bus.flush && bus.ex_stall) m_valid = m_valid | 1'b0;
    end
    if (rst_n == 1'b1 && accept) begin
      m_valid = bus.in_valid; m_a = opa; m_b = opb; m_rd = bus.in_rd;
      m_wr = bus.in_writes_rd; m_ld = bus.in_is_load;
    end
    chk("out_valid", bus.out_valid, m_valid);
    chk("out_operand_a", bus.out_operand_a, m_a);
    chk("out_operand_b", bus.out_operand_b, m_b);
    chk("out_rd", bus.out_rd, m_rd);
    chk("out_writes_rd", bus.out_writes_rd, m_wr);
    chk("out_is_load", bus.out_is_load, m_ld);
    chk("load_use_stalls", bus.load_use_stalls, m_cnt);
  endtask

  initial begin
    m_valid = 0; m_a = 0; m_b = 0; m_rd = 0; m_wr = 0; m_ld = 0; m_cnt = 0;
    for (int i = 0; i < NUM_REGS; i++) bank[i] = $urandom;
    set_idle();
    @(negedge clk);
    rst_n = 0;
    cycle();
    chk("reset_valid", bus.out_valid, 0);
    chk("reset_cnt", bus.load_use_stalls, 0);
    rst_n = 1;

    bank[3] = 32'h11; bank[4] = 32'h22;
    bus.in_valid = 1; bus.in_rs_a = 3; bus.in_rs_b = 4; bus.in_rd = 5;
    bus.in_use_a = 1; bus.in_use_b = 1; bus.in_writes_rd = 1;
    cycle();
    chk("nohaz_a", bus.out_operand_a, 32'h11);
    chk("nohaz_b", bus.out_operand_b, 32'h22);
    chk("nohaz_valid", bus.out_valid, 1);

    bus.ex_valid = 1; bus.ex_writes_rd = 1; bus.ex_rd = 3; bus.ex_result = 32'hAA;
    bus.mem_valid = 1; bus.mem_writes_rd = 1; bus.mem_rd = 3; bus.mem_result = 32'hBB;
    bus.wb_write_enable = 1; bus.wb_write_reg = 3; bus.wb_write_data = 32'hCC;
    cycle();
    chk("prio_ex", bus.out_operand_a, 32'hAA);
    bus.ex_valid = 0;
    cycle();
    chk("prio_mem", bus.out_operand_a, 32'hBB);
    bus.mem_valid = 0;
    cycle();
    chk("prio_wb", bus.out_operand_a, 32'hCC);

    set_idle();
    bus.ex_valid = 1; bus.ex_is_load = 1; bus.ex_writes_rd = 1; bus.ex_rd = 7;
    bus.in_valid = 1; bus.in_use_a = 1; bus.in_rs_a = 7; bus.in_rd = 9; bus.in_writes_rd = 1;
    cycle();
    chk("lu_bubble", bus.out_valid, 0);
    chk("lu_cnt", bus.load_use_stalls, 1);
    bus.ex_valid = 0; bus.ex_is_load = 0;
    bus.mem_valid = 1; bus.mem_writes_rd = 1; bus.mem_rd = 7; bus.mem_result = 32'h5A;
    cycle();
    chk("lu_mem_fwd", bus.out_operand_a, 32'h5A);
    chk("lu_valid", bus.out_valid, 1);

    bus.ex_stall = 1; bus.in_rs_a = 2; bus.in_rd = 1;
    repeat (3) cycle();
    chk("stall_hold_a", bus.out_operand_a, 32'h5A);
    chk("stall_hold_valid", bus.out_valid, 1);
    chk("stall_cnt", bus.load_use_stalls, 1);

    set_idle();
    bus.ex_valid = 1; bus.ex_is_load = 1; bus.ex_writes_rd = 1; bus.ex_rd = 6;
    bus.in_valid = 1; bus.in_use_b = 1; bus.in_rs_b = 6; bus.flush = 1;
    cycle();
    chk("flush_lu_valid", bus.out_valid, 0);
    chk("flush_lu_cnt", bus.load_use_stalls, 1);

    set_idle();
    bus.ex_valid = 1; bus.ex_writes_rd = 1; bus.ex_rd = 0; bus.ex_result = 32'hFF;
    bus.in_valid = 1; bus.in_use_a = 1; bus.in_rs_a = 0;
    cycle();
    chk("zero_reg", bus.out_operand_a, 0);

    set_idle();
    bus.ex_valid = 1; bus.ex_is_load = 1; bus.ex_writes_rd = 1; bus.ex_rd = 5;
    bus.in_valid = 1; bus.in_use_a = 1; bus.in_rs_a = 5;
    cycle();
    chk("pre_reset_cnt", bus.load_use_stalls, 2);
    rst_n = 0;
    cycle();
    chk("rst_stall_cnt", bus.load_use_stalls, 0);
    chk("rst_stall_valid", bus.out_valid, 0);
    rst_n = 1;

    // Randomized traffic on a small register window so bypass and hazard hits are frequent.
    for (int n = 0; n < 600; n++) begin
      bus.in_valid = $urandom_range(1); bus.in_rs_a = reg_idx_t'($urandom_range(7));
      bus.in_rs_b = reg_idx_t'($urandom_range(7)); bus.in_rd = reg_idx_t'($urandom_range(31));
      bus.in_use_a = $urandom_range(1); bus.in_use_b = $urandom_range(1);
      bus.in_writes_rd = $urandom_range(1); bus.in_is_load = $urandom_range(1);
      bus.ex_valid = $urandom_range(1); bus.ex_writes_rd = $urandom_range(1);
      bus.ex_is_load = $urandom_range(1); bus.ex_rd = reg_idx_t'($urandom_range(7));
      bus.ex_result = $urandom;
      bus.mem_valid = $urandom_range(1); bus.mem_writes_rd = $urandom_range(1);
      bus.mem_rd = reg_idx_t'($urandom_range(7)); bus.mem_result = $urandom;
      bus.wb_write_enable = $urandom_range(1); bus.wb_write_reg = reg_idx_t'($urandom_range(7));
      bus.wb_write_data = $urandom;
      bus.ex_stall = ($urandom_range(7) == 0);
      bus.flush = ($urandom_range(15) == 0);
      rst_n = ($urandom_range(79) != 0);
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
